// File: rtl/song_sequencer.sv
// Song ROM sequencer: walks one song's {note, duration} entries and times each note against beat.
// Define SONG_SEQ_LOOP_EN to wrap at the last entry with a one-cycle song_done pulse.
module song_sequencer #(
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6,
    parameter int IDX_W  = 5,
    parameter int SONG_W = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     play,
    input  logic [SONG_W-1:0]        song,
    input  logic                     beat,
    output logic [SONG_W+IDX_W-1:0]  rom_addr,
    input  logic [NOTE_W+DUR_W-1:0]  rom_dout,
    output logic [NOTE_W-1:0]        note,
    output logic [DUR_W-1:0]         duration,
    output logic                     new_note,
    output logic                     playing,
    output logic                     song_done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_LOAD  = 3'd3;
    localparam logic [2:0] S_PLAY  = 3'd4;
    localparam logic [2:0] S_NEXT  = 3'd5;

    logic [2:0]        state;
    logic [SONG_W-1:0] song_q;
    logic [IDX_W-1:0]  idx;
    logic [DUR_W-1:0]  cnt;
    logic [NOTE_W-1:0] note_f;
    logic [DUR_W-1:0]  dur_f;

    assign note_f   = rom_dout[NOTE_W+DUR_W-1:DUR_W];
    assign dur_f    = rom_dout[DUR_W-1:0];
    // Address comes straight from the song/index flops, so it is stable from FETCH through LOAD.
    assign rom_addr = {song_q, idx};
    assign playing  = (state == S_PLAY) && play;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            song_q    <= '0;
            idx       <= '0;
            cnt       <= '0;
            note      <= '0;
            duration  <= '0;
            new_note  <= 1'b0;
            song_done <= 1'b0;
        end else begin
            new_note <= 1'b0;
`ifdef SONG_SEQ_LOOP_EN
            song_done <= 1'b0;
`endif
            // A song change overrides whatever the machine was doing.
            if (song != song_q) begin
                song_q    <= song;
                idx       <= '0;
                cnt       <= '0;
                song_done <= 1'b0;
                state     <= play ? S_FETCH : S_IDLE;
            end else begin
                case (state)
                    S_IDLE:  if (play && !song_done) state <= S_FETCH;
                    S_FETCH: state <= S_WAIT;
                    S_WAIT:  state <= S_LOAD;
                    S_LOAD: begin
                        if (dur_f == '0) begin
                            state <= S_NEXT;
                        end else begin
                            note     <= note_f;
                            duration <= dur_f;
                            cnt      <= dur_f;
                            new_note <= 1'b1;
                            state    <= S_PLAY;
                        end
                    end
                    S_PLAY: begin
                        // cnt is never 0 here: LOAD only enters PLAY with a nonzero duration.
                        if (beat && play) begin
                            cnt <= cnt - 1'b1;
                            if (cnt == DUR_W'(1)) state <= S_NEXT;
                        end
                    end
                    S_NEXT: begin
                        if (idx == '1) begin
                            song_done <= 1'b1;
`ifdef SONG_SEQ_LOOP_EN
                            idx   <= '0;
                            state <= S_FETCH;
`else
                            state <= S_IDLE;
`endif
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_FETCH;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Sequences a song ROM: walks one song's entries, issues each {note, duration} to the note player, and times each note against the beat tick.
- Sits between the top-level play/song controls and the song ROM, and feeds the note player.
- The ROM holds 4 songs of 32 entries each: addr = {song[1:0], idx[4:0]}, data = {note[11:6], duration[5:0]}.
- The ROM is synchronous: dout is registered one clk after addr.

Parameters:
- NOTE_W, 6, note code width (0 = rest)
- DUR_W, 6, duration width in beats
- IDX_W, 5, entry-index width per song (32 entries)
- SONG_W, 2, song-select width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- play  in  1  level; 1 = run, 0 = pause
- song  in  SONG_W  song select
- beat  in  1  one-cycle beat strobe
- rom_addr  out  SONG_W+IDX_W  ROM address, registered
- rom_dout  in  NOTE_W+DUR_W  ROM data, valid the 2nd cycle after rom_addr changes
- note  out  NOTE_W  current note, held until the next load
- duration  out  DUR_W  current note duration
- new_note  out  1  one-cycle pulse when note/duration update
- playing  out  1  1 while in PLAY with play=1
- song_done  out  1  sticky; last entry of the song finished

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high. While reset=1, all outputs are 0, idx=0, the beat counter is 0, and the latched song is 0. The state machine enters IDLE.
- States: IDLE, FETCH, WAIT, LOAD, PLAY, NEXT.
- IDLE: if play=1 and song_done=0, go to FETCH; otherwise stay.
- FETCH: rom_addr = {song_q, idx} is valid. Go to WAIT.
- WAIT: the ROM registers its data. Go to LOAD.
- LOAD: capture rom_dout.
  - duration field == 0: the entry is skipped. No new_note; note/duration are unchanged; go to NEXT.
  - duration field != 0: register note/duration, load cnt = duration, pulse new_note, go to PLAY.
- PLAY:
  - beat=1 and play=1: cnt decrements.
  - cnt reaches 0: go to NEXT.
  - play=0: cnt is frozen; note is held; playing=0.
  - A beat in the same cycle as new_note counts as the first beat.
- NEXT:
  - idx == 31: set song_done=1, go to IDLE. idx stays 31.
  - Otherwise: idx++, go to FETCH.
- Latency:
  - play sampled in IDLE in cycle n: new_note is high in cycle n+4.
  - Note-to-note gap: 4 cycles (NEXT, FETCH, WAIT, LOAD) after the final beat.
- Rests: note 0 is issued like any other note (with new_note). The player silences on code 0.
- Song change:
  - song != song_q, sampled in any state: next cycle song_q = song, idx = 0, song_done = 0, cnt = 0.
  - The state then goes to FETCH if play=1, otherwise IDLE.
  - This change takes priority over every other transition.
- play toggling in FETCH/WAIT/LOAD does not stall the fetch; only PLAY and IDLE honour play.
- Reset asserted mid-note returns everything to the reset values immediately.

Optional Feature:
- Macro SONG_SEQ_LOOP_EN.
- Defined: NEXT at idx==31 wraps idx to 0 and goes to FETCH. song_done pulses for one cycle per wrap instead of being sticky.
- Undefined: the sticky song_done / IDLE behaviour above applies.

Test Plan:
- Reset mid-PLAY:
  - Stimulus: reset=1 while cnt=5 in song 1.
  - Required: note=0, duration=0, new_note=0, rom_addr=0, song_done=0, all in the same cycle as the reset assertion; after release the state is IDLE.
- First note, song 0, with a beat every 20 cycles:
  - Stimulus: play=1.
  - Required: rom_addr=0 in FETCH; new_note 4 cycles after play with note=49, duration=12.
  - Required: after 12 beats, 4 cycles later, new_note with note=1, duration=8, rom_addr=1.
- Zero-duration skip and done, song 0 from idx 27:
  - Required: entries 28–31 (durations 0) produce no new_note.
  - Required: song_done=1 after entry 27's 8 beats plus 4×4 cycles; then the block stays in IDLE with play=1.
- Pause:
  - Stimulus: song 1 playing note=35, duration=36; drop play after 10 beats; send 5 beats with play=0; raise play again.
  - Required: playing=0, note stays 35, cnt stays 26.
  - Required: 26 further beats are needed before entry 33 (note=42).
- Song switch:
  - Stimulus: song 0→2 mid-note with play=1.
  - Required: rom_addr=64 in the following FETCH; new_note with note=43, duration=6; song_done cleared.
- Loop (SONG_SEQ_LOOP_EN defined):
  - Stimulus: play song 3 to its end.
  - Required: one-cycle song_done pulse, then rom_addr=96 refetched; new_note with note=38, duration=6.
